// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port 8x16 register RAM.
// After reset it zero-fills every word, then serves single-word req/ack transactions.
module ram_arbiter #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          init_done,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e        state_q;
  logic [AW:0]   cnt_q;
  logic          prio_q;   // 0 = A has priority, 1 = B
  logic          owner_q;  // 0 = A, 1 = B
  logic          we_q;

  logic          ack_a_q;
  logic          ack_b_q;
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;
  logic          init_done_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [AW-1:0] rd_addr_q;

  logic          elig_a;
  logic          elig_b;
  logic          grant;
  logic          pick_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // A requester whose ack is still high is finishing, not asking again.
  always_comb begin
    elig_a    = req_a && !ack_a_q;
    elig_b    = req_b && !ack_b_q;
    grant     = elig_a || elig_b;
    pick_b    = elig_b && (!elig_a || prio_q);
    sel_we    = pick_b ? we_b    : we_a;
    sel_addr  = pick_b ? addr_b  : addr_a;
    sel_wdata = pick_b ? wdata_b : wdata_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      init_done_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          // cnt never exceeds 2^AW, so its MSB alone marks the end of the fill.
          if (!cnt_q[AW]) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q[AW-1:0];
            wr_data_q <= '0;
            cnt_q     <= cnt_q + (AW+1)'(1);
          end else begin
            wr_en_q     <= 1'b0;
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        S_IDLE: begin
          wr_en_q <= 1'b0;
          if (grant) begin
            owner_q <= pick_b;
            we_q    <= sel_we;
            if (sel_we) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= sel_addr;
              wr_data_q <= sel_wdata;
            end else begin
              rd_addr_q <= sel_addr;
            end
            prio_q  <= !pick_b;
            state_q <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          wr_en_q <= 1'b0;
          if (owner_q) begin
            ack_b_q <= 1'b1;
            if (!we_q) rdata_b_q <= ram_rd_data;
          end else begin
            ack_a_q <= 1'b1;
            if (!we_q) rdata_a_q <= ram_rd_data;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_INIT;
      endcase
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign init_done   = init_done_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 8x16 RAM
// (registered write, asynchronous read) attached to the RAM ports.
module tb_ram_arbiter;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ack_a, ack_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          init_done, ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .init_done(init_done), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8];
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  int n_cmp  = 0;
  int n_fail = 0;
  int nb_ack = 0;
  always @(negedge clk) if (ack_b === 1'b1) nb_ack++;

  logic [63:0] all_outs;
  assign all_outs = 64'({ack_a, ack_b, rdata_a, rdata_b, init_done, ram_wr_en,
                         ram_wr_addr, ram_wr_data, ram_rd_addr});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs the 9 init edges after reset release; optionally raises an A read of addr 0 after edge 3.
  task automatic init_seq(input bit raise_req);
    logic [21:0] ie;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      ie = {(k <= 8), 3'(k <= 8 ? k - 1 : 7), 16'h0000, (k >= 9), 1'b0};
      chk($sformatf("init_e%0d", k), 64'({ram_wr_en, ram_wr_addr, ram_wr_data, init_done, ack_a}), 64'(ie));
      if (raise_req && k == 3) begin
        we_a = 1'b0; addr_a = '0; req_a = 1'b1;
      end
    end
  endtask

  // Idles one edge, then issues one A transaction; lat = edges from request to ack.
  task automatic txn_a(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                       output int lat, output logic [63:0] snap);
    @(posedge clk); #1;
    we_a = we; addr_a = ad; wdata_a = wd; req_a = 1'b1;
    lat = 0;
    snap = '0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) snap = 64'({ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr});
    end while (ack_a !== 1'b1 && lat < 20);
    req_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          nb0;
    logic [63:0] snap;
    logic        exp_a, exp_b;

    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs, 64'h0);

    // Init sequence with a request pending from edge 3.
    @(negedge clk); rst_n = 1'b1;
    init_seq(1'b1);
    @(posedge clk); #1;
    chk("init_req_e10", 64'(ack_a), 64'h0);
    @(posedge clk); #1;
    chk("init_req_ack_e11", 64'(ack_a), 64'h1);
    chk("init_req_rdata", 64'(rdata_a), 64'h0);
    req_a = 1'b0;

    // Zero-fill readback through A.
    for (int a = 0; a < 8; a++) begin
      txn_a(1'b0, 3'(a), 16'h0, lat, snap);
      chk($sformatf("fill_lat%0d", a), 64'(lat), 64'd2);
      chk($sformatf("fill_rd%0d", a), 64'(rdata_a), 64'h0);
    end

    // Single write then read.
    nb0 = nb_ack;
    txn_a(1'b1, 3'd5, 16'hBEEF, lat, snap);
    chk("wr_lat", 64'(lat), 64'd2);
    chk("wr_regs", snap, 64'({1'b1, 3'd5, 16'hBEEF, 3'd7}));
    chk("wr_keeps_rdata", 64'(rdata_a), 64'h0);
    txn_a(1'b0, 3'd5, 16'h0, lat, snap);
    chk("rd_lat", 64'(lat), 64'd2);
    chk("rd_regs", snap, 64'({1'b0, 3'd5, 16'hBEEF, 3'd5}));
    chk("rd_data", 64'(rdata_a), 64'hBEEF);
    chk("b_quiet_ack", 64'(nb_ack - nb0), 64'd0);
    chk("b_quiet_rdata", 64'(rdata_b), 64'h0);

    // Masking: B holds req_b through its ack cycle.
    @(posedge clk); #1;
    we_b = 1'b1; addr_b = 3'd6; wdata_b = 16'h5A5A; req_b = 1'b1;
    @(posedge clk); #1; chk("mask_grant",   64'({ack_b, ram_wr_en}), 64'b01);
    @(posedge clk); #1; chk("mask_ack1",    64'({ack_b, ram_wr_en}), 64'b10);
    @(posedge clk); #1; chk("mask_hold",    64'({ack_b, ram_wr_en}), 64'b00);
    @(posedge clk); #1; chk("mask_regrant", 64'({ack_b, ram_wr_en}), 64'b01);
    @(posedge clk); #1; chk("mask_ack2",    64'({ack_b, ram_wr_en}), 64'b10);
    req_b = 1'b0;

    // Reset during the ACCESS cycle of a B read.
    @(posedge clk); #1;
    nb0 = nb_ack;
    we_b = 1'b0; addr_b = 3'd6; req_b = 1'b1;
    @(posedge clk); #1;
    chk("rst_grant_rdaddr", 64'(ram_rd_addr), 64'd6);
    #2 rst_n = 1'b0;
    #1 chk("rst_low_outs", all_outs, 64'h0);
    req_b = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_outs", all_outs, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    init_seq(1'b0);
    chk("rst_no_ack_b", 64'(nb_ack - nb0), 64'd0);

    // Contention straight after reset, then continuous alternation.
    we_a = 1'b0; addr_a = 3'd2; req_a = 1'b1;
    we_b = 1'b1; addr_b = 3'd2; wdata_b = 16'h1234; req_b = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      exp_a = (e % 4 == 2);
      exp_b = (e % 4 == 0);
      chk($sformatf("rr_e%0d", e), 64'({ack_a, ack_b}), 64'({exp_a, exp_b}));
      if (exp_a) chk($sformatf("rr_rdata_e%0d", e), 64'(rdata_a), (e == 2) ? 64'h0 : 64'h1234);
      if (exp_b) begin
        addr_b  = 3'(2 + e / 4);
        wdata_b = 16'(32'hB000 + 32'(e));
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("rr_rdata_b", 64'(rdata_b), 64'h0);

    // Post-reinit contents: 6 was zero-filled again, 3 and 5 hold contention writes.
    txn_a(1'b0, 3'd6, 16'h0, lat, snap);
    chk("refill_rd6", 64'(rdata_a), 64'h0);
    txn_a(1'b0, 3'd3, 16'h0, lat, snap);
    chk("rr_wr_rd3", 64'(rdata_a), 64'hB004);
    txn_a(1'b0, 3'd5, 16'h0, lat, snap);
    chk("rr_wr_rd5", 64'(rdata_a), 64'hB00C);
    chk("rr_wr_lat", 64'(lat), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
